// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers results from ALU0, ALU1 and LSU in private
// FIFOs and grants up to two per cycle onto registered CDB slots, round-robin.
module cdb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              src_valid_0,
  input  logic [DATA_W-1:0] src_data_0,
  input  logic [TAG_W-1:0]  src_tag_0,
  input  logic              src_valid_1,
  input  logic [DATA_W-1:0] src_data_1,
  input  logic [TAG_W-1:0]  src_tag_1,
  input  logic              src_valid_2,
  input  logic [DATA_W-1:0] src_data_2,
  input  logic [TAG_W-1:0]  src_tag_2,
  output logic              src_ready_0,
  output logic              src_ready_1,
  output logic              src_ready_2,
  output logic              cdb_valid_0,
  output logic [DATA_W-1:0] cdb_data_0,
  output logic [TAG_W-1:0]  cdb_tag_0,
  output logic              cdb_valid_1,
  output logic [DATA_W-1:0] cdb_data_1,
  output logic [TAG_W-1:0]  cdb_tag_1,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + TAG_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  logic [2:0]    w_valid;
  logic [2:0]    w_ready;
  logic [2:0]    w_push;
  logic [2:0]    w_pop;
  logic [EW-1:0] w_wdata [3];
  logic [EW-1:0] w_head [3];
  logic [EW-1:0] r_mem [3][FIFO_DEPTH];
  logic [AW-1:0] r_wptr [3];
  logic [AW-1:0] r_rptr [3];
  logic [CW-1:0] r_cnt [3];
  logic [CW-1:0] w_cnt_nxt [3];
  logic [1:0]    r_rr;
  logic [1:0]    w_rr_nxt;
  logic [2:0][1:0] w_order;
  logic [1:0]    w_s;
  logic          w_g0_v;
  logic          w_g1_v;
  logic [1:0]    w_g0_src;
  logic [1:0]    w_g1_src;
  logic [1:0]    w_last;
  logic [EW-1:0] w_g0_ent;
  logic [EW-1:0] w_g1_ent;

  assign w_valid    = {src_valid_2, src_valid_1, src_valid_0};
  assign w_wdata[0] = {src_data_0, src_tag_0};
  assign w_wdata[1] = {src_data_1, src_tag_1};
  assign w_wdata[2] = {src_data_2, src_tag_2};

  assign src_ready_0 = w_ready[0];
  assign src_ready_1 = w_ready[1];
  assign src_ready_2 = w_ready[2];
  assign busy = (r_cnt[0] != ZERO_C) | (r_cnt[1] != ZERO_C) | (r_cnt[2] != ZERO_C);

  // Ready comes from state only; a full FIFO stays closed even while popping.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ready[i] = (r_cnt[i] < DEPTH_C);
      w_head[i]  = r_mem[i][r_rptr[i]];
      w_push[i]  = w_valid[i] & w_ready[i] & ~flush;
    end
  end

  // Scan sources starting at rr_ptr; the first two non-empty heads win slots 0 and 1.
  always_comb begin
    w_g0_v   = 1'b0;
    w_g1_v   = 1'b0;
    w_g0_src = 2'd0;
    w_g1_src = 2'd0;
    w_s      = 2'd0;
    case (r_rr)
      2'd1:    w_order = {2'd0, 2'd2, 2'd1};
      2'd2:    w_order = {2'd1, 2'd0, 2'd2};
      default: w_order = {2'd2, 2'd1, 2'd0};
    endcase
    for (int k = 0; k < 3; k++) begin
      w_s = w_order[k];
      if (r_cnt[w_s] != ZERO_C) begin
        if (!w_g0_v) begin
          w_g0_v   = 1'b1;
          w_g0_src = w_s;
        end else if (!w_g1_v) begin
          w_g1_v   = 1'b1;
          w_g1_src = w_s;
        end else begin
          w_g1_v = w_g1_v;
        end
      end else begin
        w_g0_v = w_g0_v;
      end
    end
  end

  // Grant muxes, pop strobes and the next round-robin pointer.
  always_comb begin
    case (w_g0_src)
      2'd1:    w_g0_ent = w_head[1];
      2'd2:    w_g0_ent = w_head[2];
      default: w_g0_ent = w_head[0];
    endcase
    case (w_g1_src)
      2'd1:    w_g1_ent = w_head[1];
      2'd2:    w_g1_ent = w_head[2];
      default: w_g1_ent = w_head[0];
    endcase
    for (int i = 0; i < 3; i++) begin
      w_pop[i] = ((w_g0_v && (w_g0_src == 2'(i))) || (w_g1_v && (w_g1_src == 2'(i)))) && !flush;
    end
    w_last   = w_g1_v ? w_g1_src : w_g0_src;
    w_rr_nxt = (w_last == 2'd2) ? 2'd0 : (w_last + 2'd1);
  end

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      case ({w_push[i], w_pop[i]})
        2'b10:   w_cnt_nxt[i] = r_cnt[i] + ONE_C;
        2'b01:   w_cnt_nxt[i] = r_cnt[i] - ONE_C;
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= w_wdata[i];
      end
    end
  end

  // FIFO pointers and counts; flush squashes everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i]  <= ZERO_C;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i]  <= ZERO_C;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + 1'b1;
        end
      end
    end
  end

  // Registered CDB slots; an ungranted slot keeps its data/tag and drops valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr        <= 2'd0;
      cdb_valid_0 <= 1'b0;
      cdb_valid_1 <= 1'b0;
      cdb_data_0  <= '0;
      cdb_tag_0   <= '0;
      cdb_data_1  <= '0;
      cdb_tag_1   <= '0;
    end else if (flush) begin
      r_rr        <= 2'd0;
      cdb_valid_0 <= 1'b0;
      cdb_valid_1 <= 1'b0;
    end else begin
      cdb_valid_0 <= w_g0_v;
      cdb_valid_1 <= w_g1_v;
      if (w_g0_v) begin
        {cdb_data_0, cdb_tag_0} <= w_g0_ent;
        r_rr <= w_rr_nxt;
      end
      if (w_g1_v) begin
        {cdb_data_1, cdb_tag_1} <= w_g1_ent;
      end
    end
  end
endmodule
